// File: rtl/demux1x4_tdm.sv
// Time-division 1:4 demultiplexer. It drives the s1/s0 select pair to a paired
// 4:1 mux and rebuilds the returned serial beats into a 4-lane frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a sof beat; non-sof beats are dropped silently
// COLLECT | lane 0 captured, gathering lanes 1..3; cnt = next lane
module demux1x4_tdm #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sof,
  output logic               s1,
  output logic               s0,
  output logic [4*WIDTH-1:0] y,
  output logic               out_valid,
  output logic               frame_err,
  output logic [CNT_W-1:0]   frame_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  // {s1,s0} is always the inverse of the slot count, updated together with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      {s1, s0}  <= 2'b11;
      shadow0   <= '0;
      shadow1   <= '0;
      shadow2   <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            if (sof) begin
              shadow0  <= din;
              cnt      <= 2'd1;
              {s1, s0} <= 2'b10;
              state    <= COLLECT;
            end
          end
          COLLECT: begin
            if (sof) begin
              // Restart: the partial frame is dropped and this beat becomes lane 0.
              frame_err <= 1'b1;
              shadow0   <= din;
              cnt       <= 2'd1;
              {s1, s0}  <= 2'b10;
            end else begin
              case (cnt)
                2'd1: begin
                  shadow1  <= din;
                  cnt      <= 2'd2;
                  {s1, s0} <= 2'b01;
                end
                2'd2: begin
                  shadow2  <= din;
                  cnt      <= 2'd3;
                  {s1, s0} <= 2'b00;
                end
                default: begin
                  y         <= {din, shadow2, shadow1, shadow0};
                  out_valid <= 1'b1;
                  frame_cnt <= frame_cnt + 1'b1;
                  cnt       <= 2'd0;
                  {s1, s0}  <= 2'b11;
                  state     <= IDLE;
                end
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Bench for demux1x4_tdm: directed scenarios plus random traffic, checked
// against a queue-based frame model.
module tb_demux1x4_tdm;
  localparam int W = 1;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          sof;
  logic          s1, s0;
  logic [4*W-1:0] y;
  logic          out_valid;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  demux1x4_tdm #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .s1(s1), .s0(s0), .y(y), .out_valid(out_valid), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats of the frame in progress, and expected outputs.
  logic [W-1:0]   q[$];
  logic [4*W-1:0] exp_y;
  logic           exp_ov;
  logic           exp_err;
  logic [CW-1:0]  exp_cnt;
  logic [1:0]     exp_sel;

  task automatic step(input logic r, input logic [W-1:0] d, input logic v, input logic s);
    rst = r; din = d; din_valid = v; sof = s;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_y = '0; exp_ov = 1'b0; exp_err = 1'b0; exp_cnt = '0;
    end else begin
      exp_ov = 1'b0; exp_err = 1'b0;
      if (v) begin
        if (s) begin
          if (q.size() != 0) exp_err = 1'b1;
          q.delete();
          q.push_back(d);
        end else if (q.size() != 0) begin
          q.push_back(d);
          if (q.size() == 4) begin
            for (int k = 0; k < 4; k++) exp_y[k*W +: W] = q[k];
            exp_ov = 1'b1;
            exp_cnt = exp_cnt + 1'b1;
            q.delete();
          end
        end
      end
    end
    // Next lane to be accepted is q.size(); select encodes 3 - lane.
    exp_sel = 2'(3 - q.size());
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic s);
    step(1'b0, d, 1'b1, s);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, W'($urandom), 1'($urandom), 1'($urandom));
      n_tests++;
      if (y !== '0 || out_valid !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== '0 || {s1, s0} !== 2'b11) begin
        n_fail++;
        $display("FAIL reset: y=%h ov=%b err=%b cnt=%0d sel=%b, required y=0 ov=0 err=0 cnt=0 sel=11",
                 y, out_valid, frame_err, frame_cnt, {s1, s0});
      end
    end
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_single_frame();
    logic [3:0] bits;
    logic [1:0] sels [4];
    bits = 4'b1101;  // lane0=1, lane1=0, lane2=1, lane3=1
    sels = '{2'b10, 2'b01, 2'b00, 2'b11};
    n_tests++;
    if ({s1, s0} !== 2'b11) begin
      n_fail++; $display("FAIL single_sel_idle: got %b, required 11", {s1, s0});
    end
    for (int k = 0; k < 4; k++) begin
      beat(W'(bits[k]), k == 0);
      n_tests++;
      if ({s1, s0} !== sels[k]) begin
        n_fail++; $display("FAIL single_sel beat%0d: got %b, required %b", k, {s1, s0}, sels[k]);
      end
      if (k < 3) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL single_early_valid beat%0d: got %b, required 0", k, out_valid);
        end
      end
    end
    n_tests++;
    if (y !== 4'b1101 || out_valid !== 1'b1 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_frame: y=%b ov=%b cnt=%0d, required y=1101 ov=1 cnt=1", y, out_valid, frame_cnt);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || y !== 4'b1101) begin
      n_fail++; $display("FAIL single_pulse: ov=%b y=%b, required ov=0 y=1101", out_valid, y);
    end
  endtask

  task automatic test_stall();
    logic [CW-1:0] c0;
    c0 = frame_cnt;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, W'($urandom), 1'b0, 1'($urandom));
      n_tests++;
      if ({s1, s0} !== 2'b01 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: sel=%b ov=%b, required sel=01 ov=0", i, {s1, s0}, out_valid);
      end
    end
    beat(1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_early_valid: got %b, required 0", out_valid);
    end
    beat(1'b1, 1'b0);
    n_tests++;
    if (y !== 4'b1101 || out_valid !== 1'b1 || frame_cnt !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL stall_frame: y=%b ov=%b cnt=%0d, required y=1101 ov=1 cnt=%0d", y, out_valid, frame_cnt, CW'(c0 + 1));
    end
  endtask

  task automatic test_abort();
    logic [CW-1:0] c0;
    c0 = frame_cnt;
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    n_tests++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0 || {s1, s0} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_restart: err=%b ov=%b sel=%b, required err=1 ov=0 sel=10", frame_err, out_valid, {s1, s0});
    end
    beat(1'b0, 1'b0);
    n_tests++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL abort_err_pulse: got %b, required 0", frame_err);
    end
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    n_tests++;
    if (y !== 4'b0100 || out_valid !== 1'b1 || frame_cnt !== CW'(c0 + 1)) begin
      n_fail++;
      $display("FAIL abort_frame: y=%b ov=%b cnt=%0d, required y=0100 ov=1 cnt=%0d", y, out_valid, frame_cnt, CW'(c0 + 1));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      beat(W'($urandom), 1'b0);
      n_tests++;
      if (out_valid !== 1'b0 || {s1, s0} !== 2'b11 || frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL stray%0d: ov=%b sel=%b err=%b, required ov=0 sel=11 err=0", i, out_valid, {s1, s0}, frame_err);
      end
    end
    for (int k = 0; k < 8; k++) begin
      beat(W'($urandom), (k % 4) == 0);
      n_tests++;
      if (out_valid !== ((k % 4) == 3) || y !== exp_y || frame_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL b2b%0d: ov=%b y=%h cnt=%0d, required ov=%b y=%h cnt=%0d",
                 k, out_valid, y, frame_cnt, (k % 4) == 3, exp_y, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap_reset();
    step(1'b1, '0, 1'b0, 1'b0);
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < 4; k++) beat(W'($urandom), k == 0);
    n_tests++;
    if (frame_cnt !== '0 || out_valid !== 1'b1 || y !== exp_y) begin
      n_fail++;
      $display("FAIL wrap: cnt=%0d ov=%b y=%h, required cnt=0 ov=1 y=%h", frame_cnt, out_valid, y, exp_y);
    end
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (y !== '0 || {s1, s0} !== 2'b11 || frame_cnt !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: y=%h sel=%b cnt=%0d ov=%b, required y=0 sel=11 cnt=0 ov=0", y, {s1, s0}, frame_cnt, out_valid);
    end
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    n_tests++;
    if (y !== 4'b0110 || out_valid !== 1'b1 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL post_reset_frame: y=%b ov=%b cnt=%0d, required y=0110 ov=1 cnt=1", y, out_valid, frame_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0));
      n_tests++;
      if (y !== exp_y || out_valid !== exp_ov || frame_err !== exp_err ||
          frame_cnt !== exp_cnt || {s1, s0} !== exp_sel) begin
        n_fail++;
        $display("FAIL random%0d: y=%h ov=%b err=%b cnt=%0d sel=%b, required y=%h ov=%b err=%b cnt=%0d sel=%b",
                 i, y, out_valid, frame_err, frame_cnt, {s1, s0},
                 exp_y, exp_ov, exp_err, exp_cnt, exp_sel);
      end
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sof = 1'b0;
    exp_y = '0; exp_ov = 1'b0; exp_err = 1'b0; exp_cnt = '0; exp_sel = 2'b11;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_stall();
    test_abort();
    test_back_to_back();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
